// File: rtl/countdown_timer.sv
// Countdown timer mode for the digital watch: mm:ss preset entry, 1 Hz countdown
// derived from clk, and a timed alarm that restores the preset on expiry or acknowledge.
module countdown_timer #(
    parameter int unsigned TICK       = 50_000_000,
    parameter int unsigned ALARM_SECS = 10,
    parameter int unsigned MAX_MINS   = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       inc_min,
    input  logic       inc_sec,
    output logic [5:0] mins,
    output logic [5:0] secs,
    output logic       running,
    output logic       alarm
);

    localparam int unsigned PW = $clog2(TICK);
    localparam int unsigned AW = (ALARM_SECS < 2) ? 1 : $clog2(ALARM_SECS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK - 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SECS - 1);
    localparam logic [5:0]    MAX_M      = 6'(MAX_MINS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_ALARM} state_e;

    state_e        state_q, state_d;
    logic [5:0]    mins_q, mins_d;
    logic [5:0]    secs_q, secs_d;
    logic [11:0]   preset_q, preset_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [AW-1:0] acnt_q, acnt_d;
    logic          running_q, running_d;
    logic          alarm_q, alarm_d;

    logic          tick;
    logic          is_zero;
    logic [5:0]    mins_inc, secs_inc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            mins_q    <= '0;
            secs_q    <= '0;
            preset_q  <= '0;
            presc_q   <= '0;
            acnt_q    <= '0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mins_q    <= mins_d;
            secs_q    <= secs_d;
            preset_q  <= preset_d;
            presc_q   <= presc_d;
            acnt_q    <= acnt_d;
            running_q <= running_d;
            alarm_q   <= alarm_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mins_d   = mins_q;
        secs_d   = secs_q;
        preset_d = preset_q;
        presc_d  = presc_q;
        acnt_d   = acnt_q;
        tick     = (presc_q == PRESC_LAST);
        is_zero  = (mins_q == 6'd0) && (secs_q == 6'd0);
        mins_inc = (mins_q >= MAX_M) ? 6'd0 : mins_q + 6'd1;
        secs_inc = (secs_q >= 6'd59) ? 6'd0 : secs_q + 6'd1;

        if (clear) begin
            state_d  = S_IDLE;
            mins_d   = '0;
            secs_d   = '0;
            preset_d = '0;
            presc_d  = '0;
            acnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE, S_PAUSE: begin
                    // A valid start/resume takes the cycle; field edits apply otherwise.
                    if (start_stop && !is_zero) begin
                        state_d = S_RUN;
                        if (state_q == S_IDLE) begin
                            preset_d = {mins_q, secs_q};
                            presc_d  = '0;
                        end
                    end else begin
                        if (inc_min) mins_d = mins_inc;
                        if (inc_sec) secs_d = secs_inc;
                    end
                end
                S_RUN: begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        if (secs_q != 6'd0) begin
                            secs_d = secs_q - 6'd1;
                        end else if (mins_q != 6'd0) begin
                            mins_d = mins_q - 6'd1;
                            secs_d = 6'd59;
                        end
                    end
                    // Pause beats expiry when both land in the same cycle.
                    if (start_stop) begin
                        state_d = S_PAUSE;
                    end else if (tick && mins_d == 6'd0 && secs_d == 6'd0) begin
                        state_d = S_ALARM;
                        acnt_d  = '0;
                    end
                end
                S_ALARM: begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (start_stop || (tick && acnt_q == ALARM_LAST)) begin
                        state_d          = S_IDLE;
                        {mins_d, secs_d} = preset_q;
                        acnt_d           = '0;
                    end else if (tick) begin
                        acnt_d = acnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        running_d = (state_d == S_RUN);
        alarm_d   = (state_d == S_ALARM);
    end

    assign mins    = mins_q;
    assign secs    = secs_q;
    assign running = running_q;
    assign alarm   = alarm_q;

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Countdown timer mode for the digital watch. It is the down-counting counterpart of the stopwatch.
- The user loads a preset in mm:ss using the debounced, fast-advanced key pulses. The block then counts down to 00:00 at 1 Hz, derived from clk, and raises an alarm.
- Its outputs feed BinToDec/SSEG_FLASH and the mode mux, the same way the stopwatch outputs do.

Parameters:
- TICK, 50_000_000, clk cycles per timer second. Must be >= 2.
- ALARM_SECS, 10, number of timer seconds the alarm stays asserted before auto-return to IDLE.
- MAX_MINS, 59, upper limit of the minutes field for setting.

Ports:
- clk  input  1  system clock (CLOCK_50).
- reset  input  1  asynchronous, active-low reset.
- start_stop  input  1  single-cycle pulse; starts, pauses, resumes, or acknowledges the alarm.
- clear  input  1  single-cycle pulse; returns to IDLE with all fields zeroed.
- inc_min  input  1  single-cycle pulse (FASTADVANCE out); minutes +1.
- inc_sec  input  1  single-cycle pulse; seconds +1.
- mins  output  6  current minutes, 0..MAX_MINS.
- secs  output  6  current seconds, 0..59.
- running  output  1  high in RUN.
- alarm  output  1  high in ALARM.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; mins=0, secs=0; preset=0; prescaler=0; alarm counter=0; running=0; alarm=0. All outputs are registered.
- States: IDLE, RUN, PAUSE, ALARM.
- Prescaler:
  - Counts 0..TICK-1 only in RUN. tick=1 in the cycle where prescaler==TICK-1; prescaler then wraps to 0.
  - Holds its value in PAUSE. Cleared to 0 on entry to RUN from IDLE.
  - The first decrement after a start therefore occurs TICK cycles after the start pulse.
- Decrement on tick, in RUN:
  - secs>0: secs-1.
  - Otherwise, if mins>0: mins-1 and secs=59.
  - Registered, so visible the cycle after tick.
  - If the result is 00:00: next state is ALARM, alarm=1 in that same update cycle, running=0.
- IDLE:
  - inc_sec: secs 59->0 wrap, no carry into mins.
  - inc_min: mins MAX_MINS->0 wrap.
  - inc_min and inc_sec in the same cycle: both apply.
  - start_stop with mins=secs=0: ignored.
  - Otherwise start_stop: preset<={mins,secs}, state goes to RUN.
- RUN: start_stop -> PAUSE. inc_* ignored.
- PAUSE:
  - start_stop -> RUN, prescaler resumes from its held value.
  - inc_* adjust fields with the IDLE wrap rules; preset is unchanged.
  - If the fields become 00:00, a start_stop in PAUSE is ignored.
- ALARM:
  - Counts timer seconds using the prescaler (free-running in ALARM).
  - After ALARM_SECS seconds, or on start_stop: IDLE with {mins,secs}<=preset, alarm=0.
  - inc_* ignored.
- clear: in any state -> IDLE, mins=secs=0, preset=0, prescaler=0, alarm=0. clear has priority over start_stop, inc_*, and tick in the same cycle.
- start_stop coincident with tick in RUN: PAUSE wins; that tick's decrement is still applied.
- Reset mid-RUN or mid-ALARM: immediate return to reset values; no pending tick survives.

Test Plan (TICK=5, ALARM_SECS=3, MAX_MINS=59):
- Reset, then inc_sec x3 and inc_min x1 -> mins=1, secs=3. start_stop -> running=1; secs=2 appears 5 cycles after the start pulse.
- Preset 00:02, start -> 00:01 after 5 cycles, 00:00 after 10 cycles with alarm=1, running=0. After 15 more cycles: alarm=0, state IDLE, display 00:02.
- Preset 01:00, start, one tick -> 00:59, no borrow error. inc_sec at secs=59 in IDLE -> secs=0, mins unchanged. inc_min at 59 -> 0.
- Start from 00:05, start_stop after 3 cycles (PAUSE), wait 20 cycles -> no change. start_stop -> decrement occurs 2 cycles later (prescaler resumed).
- start_stop in IDLE at 00:00 -> remains IDLE, running=0. clear and start_stop in the same cycle during RUN -> IDLE, 00:00, preset=0.
- Assert reset low asynchronously mid-ALARM, between clock edges -> alarm=0, mins=secs=0 immediately, without waiting for a clk edge.
